// File: rtl/vector_response_checker.sv
// Sweeps a 3-bit stimulus index across a small DUT and compares its d/e responses
// against expected truth tables. Optional first-mismatch log: CHECKER_FIRST_ERR_LOG_EN.
module vector_response_checker #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  input  logic       e,
  input  logic [7:0] exp_d,
  input  logic [7:0] exp_e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_err_valid,
  output logic [2:0] first_err_idx,
  output logic [1:0] first_err_de
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_nxt_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_err;
  logic       w_start_ok;
  logic       w_mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_start_ok  = 1'b0;
    w_mismatch  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_nxt_state = ST_SETTLE;
          w_start_ok  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) w_nxt_state = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // one mismatch per vector, however many response bits disagree
        w_mismatch  = (d != exp_d[r_idx]) || (e != exp_e[r_idx]);
        w_nxt_state = (r_idx == 3'd7) ? ST_DONE : ST_SETTLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= 3'd0;
      r_cnt <= 4'd0;
      r_err <= 4'd0;
    end else if (w_start_ok) begin
      r_idx <= 3'd0;
      r_cnt <= CNT_INIT;
      r_err <= 4'd0;
    end else if (r_state == ST_SETTLE) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end else if (r_state == ST_SAMPLE) begin
      if (w_mismatch) r_err <= r_err + 4'd1;
      if (r_idx != 3'd7) begin
        r_idx <= r_idx + 3'd1;
        r_cnt <= CNT_INIT;
      end
    end
  end

`ifdef CHECKER_FIRST_ERR_LOG_EN
  logic       r_fe_valid;
  logic [2:0] r_fe_idx;
  logic [1:0] r_fe_de;

  always_ff @(posedge clk) begin
    if (!rst_n || w_start_ok) begin
      r_fe_valid <= 1'b0;
      r_fe_idx   <= 3'd0;
      r_fe_de    <= 2'b00;
    end else if (w_mismatch && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_idx   <= r_idx;
      r_fe_de    <= {d, e};
    end
  end

  assign first_err_valid = r_fe_valid;
  assign first_err_idx   = r_fe_idx;
  assign first_err_de    = r_fe_de;
`else
  assign first_err_valid = 1'b0;
  assign first_err_idx   = 3'd0;
  assign first_err_de    = 2'b00;
`endif

  assign {a, b, c}  = r_idx;
  assign busy       = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign done       = (r_state == ST_DONE);
  assign pass       = (r_state == ST_DONE) && (r_err == 4'd0);
  assign err_count  = r_err;

endmodule

// File: tb/tb_vector_response_checker.sv
// Randomized self-checking bench: a table-driven responder plays the DUT under test,
// and a per-sweep mismatch model predicts index, error count, verdict and log.
module tb_vector_response_checker;

  localparam int S   = 4;
  localparam int VEC = S + 1;
  localparam int LAT = 8 * VEC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, c, d, e;
  logic [7:0] exp_d = 8'h00, exp_e = 8'h00;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic       first_err_valid;
  logic [2:0] first_err_idx;
  logic [1:0] first_err_de;

  logic [7:0] resp_d = 8'h00, resp_e = 8'h00;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign d = resp_d[{a, b, c}];
  assign e = resp_e[{a, b, c}];

  vector_response_checker #(.SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .exp_d(exp_d), .exp_e(exp_e),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_de(first_err_de)
  );

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Vectors below 'upto' whose response disagrees with either truth table.
  function automatic int model_errs(input logic [7:0] ed, ee, rd, re, input int upto);
    int n = 0;
    for (int i = 0; i < upto; i++)
      if (ed[i] != rd[i] || ee[i] != re[i]) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [7:0] ed, ee, rd, re);
    for (int i = 0; i < 8; i++)
      if (ed[i] != rd[i] || ee[i] != re[i]) return i;
    return -1;
  endfunction

  task automatic chk_log(input string tag, input logic [7:0] ed, ee, rd, re);
`ifdef CHECKER_FIRST_ERR_LOG_EN
    int fi;
    fi = model_first(ed, ee, rd, re);
    chk({tag, "_fev"}, first_err_valid, (fi >= 0) ? 1 : 0);
    chk({tag, "_fei"}, first_err_idx, (fi >= 0) ? fi : 0);
    chk({tag, "_fede"}, first_err_de, (fi >= 0) ? {rd[fi], re[fi]} : 0);
`else
    chk({tag, "_fev"}, first_err_valid, 0);
    chk({tag, "_fei"}, first_err_idx, 0);
    chk({tag, "_fede"}, first_err_de, 0);
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_abc"}, {a, b, c}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fev"}, first_err_valid, 0);
    chk({tag, "_fei"}, first_err_idx, 0);
    chk({tag, "_fede"}, first_err_de, 0);
  endtask

  // One sweep. The tables are presented only on SAMPLE cycles when 'scramble' is set;
  // 'poke' re-pulses start at that cycle offset; 'rst_at' aborts the sweep there.
  task automatic sweep(input string tag, input logic [7:0] ed, ee, rd, re,
                       input bit scramble, input int poke, input int rst_at);
    resp_d = rd; resp_e = re; exp_d = ed; exp_e = ee;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      chk({tag, "_abc"}, {a, b, c}, j / VEC);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_errrun"}, err_count, model_errs(ed, ee, rd, re, j / VEC));
      if (j == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle({tag, "_midrst"});
        @(negedge clk);
        chk_idle({tag, "_postrst"});
        return;
      end
      start = (j == poke);
      if (scramble && (j % VEC) != S) begin
        exp_d = 8'($urandom); exp_e = 8'($urandom);
      end else begin
        exp_d = ed; exp_e = ee;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_d = 8'($urandom); exp_e = 8'($urandom);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_abc_end"}, {a, b, c}, 7);
    chk({tag, "_errcnt"}, err_count, model_errs(ed, ee, rd, re, 8));
    chk({tag, "_pass"}, pass, (model_errs(ed, ee, rd, re, 8) == 0) ? 1 : 0);
    chk_log(tag, ed, ee, rd, re);
    // DONE must hold regardless of table changes
    repeat (3) @(negedge clk);
    chk({tag, "_hold_done"}, done, 1);
    chk({tag, "_hold_err"}, err_count, model_errs(ed, ee, rd, re, 8));
    chk_log({tag, "_hold"}, ed, ee, rd, re);
  endtask

  initial begin
    logic [7:0] rd, re, ed, ee;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle");

    // full adder: d = sum, e = carry
    sweep("allpass", 8'h96, 8'hE8, 8'h96, 8'hE8, 1'b0, -1, -1);
    sweep("restart", 8'h96, 8'hE8, 8'h96, 8'hE8, 1'b0, -1, -1);
    sweep("onefault", 8'h97, 8'hE8, 8'h96, 8'hE8, 1'b0, -1, -1);
    sweep("allwrong", 8'h69, 8'h17, 8'h96, 8'hE8, 1'b0, -1, -1);
    sweep("busystart", 8'h96, 8'hE8, 8'h96, 8'hE8, 1'b0, 12, -1);
    sweep("midrst", 8'h97, 8'hE8, 8'h96, 8'hE8, 1'b0, -1, 20);
    sweep("afterrst", 8'h96, 8'hE9, 8'h96, 8'hE8, 1'b0, -1, -1);

    for (int t = 0; t < 12; t++) begin
      rd = 8'($urandom); re = 8'($urandom);
      ed = rd; ee = re;
      if ($urandom_range(0, 3) != 0) begin
        ed = ed ^ 8'($urandom);
        ee = ee ^ (8'($urandom) & 8'($urandom));
      end
      sweep($sformatf("rnd%0d", t), ed, ee, rd, re, t[0], (t % 3 == 0) ? 7 : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
